// File: rtl/decode_sequencer.sv
// decode_sequencer: byte-stream front end for the x86-64 decode stage.
// Buffers fetch beats, shows the oldest MAX_INS bytes to the decoder, and
// carves out one instruction per cycle using the decoder's returned length.
// Optional build macro DECSEQ_STATS_EN adds saturating stat_ins/stat_err counters.
module decode_sequencer #(
  parameter int BUF_BYTES = 32,
  parameter int MAX_INS   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 fetch_valid,
  output logic                 fetch_ready,
  input  logic [63:0]          fetch_data,
  input  logic [3:0]           fetch_nbytes,
  output logic [MAX_INS*8-1:0] win_bytes,
  output logic [4:0]           win_count,
  input  logic [4:0]           dec_len,
  input  logic                 dec_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAX_INS*8-1:0] out_bytes,
  output logic [4:0]           out_len,
  output logic                 halted
`ifdef DECSEQ_STATS_EN
  ,
  output logic [31:0]          stat_ins,
  output logic [31:0]          stat_err
`endif
);

  localparam int CW = $clog2(BUF_BYTES + 1);

  typedef enum logic [1:0] {S_FILL, S_EMIT, S_HALT} state_t;

  state_t               state_q, state_d;
  logic [7:0]           buf_q [BUF_BYTES];
  logic [7:0]           buf_d [BUF_BYTES];
  logic [CW-1:0]        count_q, count_d;
  logic [MAX_INS*8-1:0] out_bytes_q, out_bytes_d;
  logic [4:0]           out_len_q, out_len_d;

  logic cand, dec_fault, try_take, do_capture, do_halt, accept;
  int   cnt_i, len_i, pop_i, base_i, nb_i;

  assign cnt_i = int'(count_q);
  assign len_i = int'(dec_len);

  // Present the oldest buffered bytes to the decoder, zeroing positions past count
  always_comb begin
    win_bytes = '0;
    for (int i = 0; i < MAX_INS; i++) begin
      if (i < cnt_i) win_bytes[(MAX_INS-1-i)*8 +: 8] = buf_q[i];
    end
    win_count = (cnt_i >= MAX_INS) ? 5'(MAX_INS) : 5'(cnt_i);
  end

  // Classify the decoder result and work out pop, back-pressure and beat acceptance
  always_comb begin
    cand       = (cnt_i > 0) && !dec_err && (len_i >= 1) && (len_i <= MAX_INS) && (len_i <= cnt_i);
    dec_fault  = (cnt_i > 0) && (dec_err || (len_i == 0) || (len_i > MAX_INS) ||
                                 ((cnt_i >= MAX_INS) && (len_i > cnt_i)));
    try_take   = (state_q == S_FILL) || ((state_q == S_EMIT) && out_ready);
    do_capture = try_take && cand && !flush;
    do_halt    = try_take && dec_fault && !flush;
    pop_i      = do_capture ? len_i : 0;
    fetch_ready = !flush && (state_q != S_HALT) && (cnt_i - pop_i + 8 <= BUF_BYTES);
    accept     = fetch_valid && fetch_ready;
  end

  // Shift out the captured instruction and append the accepted beat behind what remains
  always_comb begin
    nb_i   = (fetch_nbytes > 4'd8) ? 8 : int'(fetch_nbytes);
    base_i = cnt_i - pop_i;
    for (int i = 0; i < BUF_BYTES; i++) begin
      buf_d[i] = 8'h00;
      if (i + pop_i < BUF_BYTES) buf_d[i] = buf_q[i + pop_i];
      if (accept && (i >= base_i) && (i < base_i + nb_i))
        buf_d[i] = fetch_data[63 - 8*(i - base_i) -: 8];
    end
  end

  // Next-state, byte count and captured-instruction logic of the FILL/EMIT/HALT machine
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    out_bytes_d = out_bytes_q;
    out_len_d   = out_len_q;
    if (flush) begin
      state_d = S_FILL;
      count_d = '0;
    end else begin
      count_d = CW'(base_i + (accept ? nb_i : 0));
      if (do_capture) begin
        state_d   = S_EMIT;
        out_len_d = dec_len;
        for (int i = 0; i < MAX_INS; i++) begin
          out_bytes_d[(MAX_INS-1-i)*8 +: 8] =
            (i < len_i) ? win_bytes[(MAX_INS-1-i)*8 +: 8] : 8'h00;
        end
      end else if (do_halt) begin
        state_d = S_HALT;
      end else if ((state_q == S_EMIT) && out_ready) begin
        state_d = S_FILL;
      end
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FILL;
      count_q     <= '0;
      out_bytes_q <= '0;
      out_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_bytes_q <= out_bytes_d;
      out_len_q   <= out_len_d;
    end
  end

  // Byte storage; contents past count are never observed so no reset is needed
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign out_valid = (state_q == S_EMIT);
  assign halted    = (state_q == S_HALT);
  assign out_bytes = out_bytes_q;
  assign out_len   = out_len_q;

`ifdef DECSEQ_STATS_EN
  logic [31:0] stat_ins_q, stat_ins_d, stat_err_q, stat_err_d;

  // Saturating counts of accepted instructions and HALT entries, kept across flush
  always_comb begin
    stat_ins_d = stat_ins_q;
    stat_err_d = stat_err_q;
    if (!flush && (state_q == S_EMIT) && out_ready && (stat_ins_q != 32'hFFFF_FFFF))
      stat_ins_d = stat_ins_q + 32'd1;
    if (do_halt && (stat_err_q != 32'hFFFF_FFFF))
      stat_err_d = stat_err_q + 32'd1;
  end

  // Statistics registers, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ins_q <= '0;
      stat_err_q <= '0;
    end else begin
      stat_ins_q <= stat_ins_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_ins = stat_ins_q;
  assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed self-checking bench for decode_sequencer.
module tb_decode_sequencer;

  logic         clk = 1'b0;
  logic         reset, flush, fetch_valid, fetch_ready;
  logic [63:0]  fetch_data;
  logic [3:0]   fetch_nbytes;
  logic [119:0] win_bytes;
  logic [4:0]   win_count, dec_len;
  logic         dec_err, out_valid, out_ready;
  logic [119:0] out_bytes;
  logic [4:0]   out_len;
  logic         halted;
`ifdef DECSEQ_STATS_EN
  logic [31:0]  stat_ins, stat_err;
`endif

  int checks = 0;
  int errors = 0;

  decode_sequencer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_data(fetch_data), .fetch_nbytes(fetch_nbytes),
    .win_bytes(win_bytes), .win_count(win_count),
    .dec_len(dec_len), .dec_err(dec_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bytes(out_bytes), .out_len(out_len),
    .halted(halted)
`ifdef DECSEQ_STATS_EN
    , .stat_ins(stat_ins), .stat_err(stat_err)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [3:0] n);
    fetch_valid  = v;
    fetch_data   = d;
    fetch_nbytes = n;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; dec_len = 5'd0; dec_err = 1'b0; out_ready = 1'b0;
    applyStimulus(1'b0, 64'h0, 4'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_win_count", win_count, 5'd0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_len", out_len, 5'd0);
    checkOutput("rst_out_bytes", out_bytes, 120'h0);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_fetch_ready", fetch_ready, 1'b1);

    $display("[TB] eight one-byte NOPs");
    dec_len = 5'd1; out_ready = 1'b1;
    applyStimulus(1'b1, 64'h9090909090909090, 4'd8);
    tick();
    applyStimulus(1'b0, 64'h0, 4'd0);
    checkOutput("nop_win_count", win_count, 5'd8);
    checkOutput("nop_win_bytes", win_bytes, {64'h9090909090909090, 56'h0});
    checkOutput("nop_wait_valid", out_valid, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput("nop_valid", out_valid, 1'b1);
      checkOutput("nop_len", out_len, 5'd1);
      checkOutput("nop_bytes", out_bytes, {8'h90, 112'h0});
      checkOutput("nop_count", win_count, 5'(7 - k));
    end
    tick();
    checkOutput("nop_done_valid", out_valid, 1'b0);
    checkOutput("nop_done_count", win_count, 5'd0);

    $display("[TB] split 7-byte MOV");
    dec_len = 5'd7;
    applyStimulus(1'b1, 64'h48C7C00000000000, 4'd3);
    tick();
    applyStimulus(1'b0, 64'h0, 4'd0);
    checkOutput("mov_part_count", win_count, 5'd3);
    checkOutput("mov_part_win", win_bytes, {24'h48C7C0, 96'h0});
    checkOutput("mov_part_valid", out_valid, 1'b0);
    checkOutput("mov_part_halt", halted, 1'b0);
    applyStimulus(1'b1, 64'h0100000000000000, 4'd4);
    tick();
    applyStimulus(1'b0, 64'h0, 4'd0);
    checkOutput("mov_full_count", win_count, 5'd7);
    checkOutput("mov_full_valid", out_valid, 1'b0);
    tick();
    checkOutput("mov_out_valid", out_valid, 1'b1);
    checkOutput("mov_out_len", out_len, 5'd7);
    checkOutput("mov_out_bytes", out_bytes, {56'h48C7C001000000, 64'h0});
    checkOutput("mov_out_count", win_count, 5'd0);
    tick();
    checkOutput("mov_done_valid", out_valid, 1'b0);

    $display("[TB] back-pressure and full boundary");
    dec_len = 5'd2; out_ready = 1'b0;
    applyStimulus(1'b1, 64'h1112131415161718, 4'd8);
    tick();
    applyStimulus(1'b0, 64'h0, 4'd0);
    tick();
    checkOutput("bp_valid", out_valid, 1'b1);
    checkOutput("bp_bytes", out_bytes, {16'h1112, 104'h0});
    checkOutput("bp_count6", win_count, 5'd6);
    applyStimulus(1'b1, 64'h2122232425262728, 4'd8);
    tick();
    applyStimulus(1'b1, 64'h3132333435363738, 4'd8);
    tick();
    applyStimulus(1'b0, 64'h0, 4'd0);
    #1;
    checkOutput("bp_ready22", fetch_ready, 1'b1);
    checkOutput("bp_count15", win_count, 5'd15);
    applyStimulus(1'b1, {16'h4142, 48'h0}, 4'd2);
    tick();
    applyStimulus(1'b0, 64'h0, 4'd0);
    #1;
    checkOutput("bp_ready24", fetch_ready, 1'b1);
    applyStimulus(1'b1, {8'h43, 56'h0}, 4'd1);
    tick();
    applyStimulus(1'b0, 64'h0, 4'd0);
    #1;
    checkOutput("bp_ready25", fetch_ready, 1'b0);
    checkOutput("bp_hold_valid", out_valid, 1'b1);
    checkOutput("bp_hold_bytes", out_bytes, {16'h1112, 104'h0});
    checkOutput("bp_hold_len", out_len, 5'd2);
    applyStimulus(1'b1, 64'h5151515151515151, 4'd8);
    tick();
    applyStimulus(1'b0, 64'h0, 4'd0);
    #1;
    checkOutput("bp_still_full", fetch_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_ready25_pop", fetch_ready, 1'b1);
    tick();
    checkOutput("drain1", out_bytes, {16'h1314, 104'h0});
    tick();
    checkOutput("drain2", out_bytes, {16'h1516, 104'h0});
    tick();
    out_ready = 1'b0;
    checkOutput("drain3", out_bytes, {16'h1718, 104'h0});
    checkOutput("drain3_valid", out_valid, 1'b1);
    checkOutput("drain_win", win_bytes, {64'h2122232425262728, 56'h31323334353637});

    $display("[TB] flush during output");
    flush = 1'b1;
    applyStimulus(1'b1, 64'hAAAAAAAAAAAAAAAA, 4'd8);
    #1;
    checkOutput("fl_ready", fetch_ready, 1'b0);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 64'h0, 4'd0);
    checkOutput("fl_valid", out_valid, 1'b0);
    checkOutput("fl_count", win_count, 5'd0);
    checkOutput("fl_halted", halted, 1'b0);
    tick();
    checkOutput("fl_dropped", win_count, 5'd0);

    $display("[TB] decode error and recovery");
    dec_len = 5'd2; dec_err = 1'b1; out_ready = 1'b1;
    applyStimulus(1'b1, {16'h0F0B, 48'h0}, 4'd2);
    tick();
    applyStimulus(1'b0, 64'h0, 4'd0);
    checkOutput("err_pre_halt", halted, 1'b0);
    checkOutput("err_count", win_count, 5'd2);
    tick();
    checkOutput("err_halted", halted, 1'b1);
    checkOutput("err_valid", out_valid, 1'b0);
    checkOutput("err_ready", fetch_ready, 1'b0);
    dec_err = 1'b0;
    applyStimulus(1'b1, 64'h0102030405060708, 4'd8);
    tick();
    applyStimulus(1'b0, 64'h0, 4'd0);
    checkOutput("err_stay", halted, 1'b1);
    checkOutput("err_no_beat", win_count, 5'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checkOutput("err_fl_halted", halted, 1'b0);
    checkOutput("err_fl_count", win_count, 5'd0);
    checkOutput("err_fl_ready", fetch_ready, 1'b1);
    dec_len = 5'd0;
    applyStimulus(1'b1, {8'hC3, 56'h0}, 4'd1);
    tick();
    applyStimulus(1'b0, 64'h0, 4'd0);
    tick();
    checkOutput("len0_halted", halted, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;

`ifdef DECSEQ_STATS_EN
    $display("[TB] statistics counters");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dec_len = 5'd1; dec_err = 1'b0; out_ready = 1'b1;
    applyStimulus(1'b1, {40'hAABBCCDDEE, 24'h0}, 4'd5);
    tick();
    applyStimulus(1'b0, 64'h0, 4'd0);
    repeat (7) tick();
    checkOutput("st_ins5", stat_ins, 32'd5);
    dec_err = 1'b1;
    applyStimulus(1'b1, {8'h0F, 56'h0}, 4'd1);
    tick();
    applyStimulus(1'b0, 64'h0, 4'd0);
    tick();
    checkOutput("st_halted", halted, 1'b1);
    checkOutput("st_ins", stat_ins, 32'd5);
    checkOutput("st_err", stat_err, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("st_ins_fl", stat_ins, 32'd5);
    checkOutput("st_err_fl", stat_err, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
